seg_scroll_ctrl: RTL and testbench
==================================

# seg_scroll_ctrl

Parametrised scrolling-data generator for the seven-segment display path. Holds a row of DIGITS packed digit codes and rotates it one digit per step tick. Step rate comes from a clock prescaler with run-time speed select. Supports selectable direction, parallel load, rotation-position tracking and an optional dwell at the home position. Output feeds the segment scan/decoder driver in place of a fixed-pattern shifter.

## Interface
- DIGITS, 6, number of digits in the row (≥2)
- DW, 4, bits per digit code
- CLK_HZ, 50_000_000, clk frequency
- STEP_HZ, 1, base step rate at speed=0; BASE = CLK_HZ/STEP_HZ, and BASE>>3 must be ≥1
- INIT, 24'h012345 (DIGITS*DW bits), reset pattern
- PAUSE_STEPS, 2, dwell length in ticks (used only with SCROLL_DWELL_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  scroll enable
- dir  in  1  0 = rotate right (low digit moves to top), 1 = rotate left
- speed  in  2  tick period = BASE>>speed cycles
- load  in  1  parallel load strobe
- load_data  in  DIGITS*DW  value loaded on load
- data_out  out  DIGITS*DW  current row
- pos  out  clog2(DIGITS)  rotation offset from home, 0..DIGITS-1
- step  out  1  one-cycle pulse, high in the cycle data_out first shows a shifted value
- wrap  out  1  one-cycle pulse coincident with step when pos returns to 0

## Operation
- Prescaler: cnt runs 0..LIM, where LIM = (BASE>>speed)-1. tick = en & (cnt==LIM). On tick, cnt returns to 0.
- en=0: cnt forced to 0, no ticks, all state held.
- If speed changes so that cnt > new LIM, cnt clears to 0 on the next edge with no tick.
- FSM states: RUN, DWELL. DWELL is reachable only with the macro.
- RUN on tick, dir=0:
  - data_out ← {data_out[DW-1:0], data_out[W-1:DW]}
  - pos ← (pos+1) mod DIGITS
- RUN on tick, dir=1:
  - data_out ← {data_out[W-DW-1:0], data_out[W-1:W-DW]}
  - pos ← pos-1, with 0 wrapping to DIGITS-1
- step=1 on every shift. wrap=1 when the new pos is 0.
- dir is sampled at each tick. A direction change takes effect on the next tick with no extra delay.
- load has the highest priority over tick and state:
  - data_out ← load_data, pos ← 0, cnt ← 0, state ← RUN
  - step/wrap = 0
  - Works regardless of en.
- Reset values: data_out=INIT, pos=0, cnt=0, state=RUN, step=0, wrap=0, dwell counter=0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.

## Timing
- Tick period is exactly LIM+1 cycles while en stays high.
- First shift occurs LIM+1 edges after en rises, after reset release, or after load.
- data_out, pos, step and wrap all update on the same edge that samples the tick. No extra pipeline stage.
- Simultaneous load and tick: load wins and no shift occurs.
- Simultaneous en fall and cnt==LIM: no tick.

## Configuration
- SCROLL_DWELL_EN defined:
  - On a shift that asserts wrap, state → DWELL.
  - In DWELL, each tick decrements the dwell counter (preloaded to PAUSE_STEPS) with no shift and no step.
  - When the counter reaches 0 on a tick, state → RUN. The following tick shifts.
  - load or rst in DWELL returns to RUN.
- SCROLL_DWELL_EN undefined:
  - No DWELL state and no dwell counter.
  - Continuous rotation. PAUSE_STEPS is ignored.

## Test plan
Common setup: CLK_HZ=8, STEP_HZ=1, DIGITS=6, DW=4, INIT=24'h012345.
- Reset, then en=1, speed=0, dir=0 → 8 cycles later data_out=501234, pos=1, step pulse. At the 6th tick data_out=012345, pos=0, step and wrap high together.
- dir=1, speed=0 → first tick data_out=123450, pos=5, no wrap. Flip dir to 0 before the 2nd tick → data_out=012345, pos=0, wrap=1.
- speed=2 → step every 2 cycles. Switch speed 0→3 when cnt=5 → cnt clears with no tick, then steps every cycle.
- load=1 with load_data=24'hABCDEF mid-count → data_out=ABCDEF and pos=0 at the next edge. 8 cycles later data_out=FABCDE.
- en=0 for 20 cycles → data_out, pos and step constant. Assert rst between edges → data_out=012345 and pos=0 before the next clk edge.
- With SCROLL_DWELL_EN and PAUSE_STEPS=2 → after the wrap tick, 2 ticks with no step and data_out held at 012345. The 3rd tick gives data_out=501234.

Source files
------------

// File: rtl/seg_scroll_ctrl.sv
// rtl/seg_scroll_ctrl.sv - rotating digit-row generator with prescaled step tick, direction, load and position tracking.
// Optional home-position dwell is built when SCROLL_DWELL_EN is defined.
module seg_scroll_ctrl #(
    parameter int                     DIGITS      = 6,
    parameter int                     DW          = 4,
    parameter int                     CLK_HZ      = 50_000_000,
    parameter int                     STEP_HZ     = 1,
    parameter logic [DIGITS*DW-1:0]   INIT        = 24'h012345,
    parameter int                     PAUSE_STEPS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        dir,
    input  logic [1:0]                  speed,
    input  logic                        load,
    input  logic [DIGITS*DW-1:0]        load_data,
    output logic [DIGITS*DW-1:0]        data_out,
    output logic [$clog2(DIGITS)-1:0]   pos,
    output logic                        step,
    output logic                        wrap
);

    localparam int W    = DIGITS * DW;
    localparam int PW   = $clog2(DIGITS);
    localparam int BASE = CLK_HZ / STEP_HZ;
    localparam int CW   = $clog2(BASE);

    localparam logic [CW-1:0] LIM0    = CW'(BASE - 1);
    localparam logic [CW-1:0] LIM1    = CW'((BASE >> 1) - 1);
    localparam logic [CW-1:0] LIM2    = CW'((BASE >> 2) - 1);
    localparam logic [CW-1:0] LIM3    = CW'((BASE >> 3) - 1);
    localparam logic [PW-1:0] POS_MAX = PW'(DIGITS - 1);

    if (((CLK_HZ / STEP_HZ) >> 3) < 1 || DIGITS < 2 || PAUSE_STEPS < 0) begin : g_bad_cfg
        $error("seg_scroll_ctrl: invalid parameter set");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] lim;
    logic          tick;
    logic          shift;

`ifdef SCROLL_DWELL_EN
    localparam int DCW = (PAUSE_STEPS < 1) ? 1 : $clog2(PAUSE_STEPS + 1);
    typedef enum logic {RUN, DWELL} state_t;
    state_t         state_q, state_d;
    logic [DCW-1:0] dwell_q, dwell_d;
`endif

    always_comb begin
        case (speed)
            2'd0:    lim = LIM0;
            2'd1:    lim = LIM1;
            2'd2:    lim = LIM2;
            default: lim = LIM3;
        endcase

        tick = en && (cnt_q == lim);
        // A count already past a newly shortened limit restarts without ticking.
        cnt_d = (load || !en || cnt_q >= lim) ? '0 : cnt_q + 1'b1;

        data_d = data_q;
        pos_d  = pos_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        shift  = tick;
`ifdef SCROLL_DWELL_EN
        state_d = state_q;
        dwell_d = dwell_q;
        if (state_q == DWELL) shift = 1'b0;
`endif

        if (load) begin
            data_d = load_data;
            pos_d  = '0;
`ifdef SCROLL_DWELL_EN
            state_d = RUN;
            dwell_d = '0;
`endif
        end else if (shift) begin
            if (!dir) begin
                data_d = {data_q[DW-1:0], data_q[W-1:DW]};
                pos_d  = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
            end else begin
                data_d = {data_q[W-DW-1:0], data_q[W-1:W-DW]};
                pos_d  = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
            end
            step_d = 1'b1;
            wrap_d = (pos_d == '0);
`ifdef SCROLL_DWELL_EN
            if (wrap_d && PAUSE_STEPS > 0) begin
                state_d = DWELL;
                dwell_d = DCW'(PAUSE_STEPS);
            end
        end else if (tick && state_q == DWELL) begin
            if (dwell_q <= DCW'(1)) begin
                state_d = RUN;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q - 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            data_q  <= INIT;
            pos_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef SCROLL_DWELL_EN
            state_q <= RUN;
            dwell_q <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
`ifdef SCROLL_DWELL_EN
            state_q <= state_d;
            dwell_q <= dwell_d;
`endif
        end
    end

    assign data_out = data_q;
    assign pos      = pos_q;
    assign step     = step_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// tb/tb_seg_scroll_ctrl.sv - scoreboard bench for seg_scroll_ctrl with CLK_HZ=8, STEP_HZ=1 (BASE=8).
module tb_seg_scroll_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        load = 1'b0;
    logic [23:0] load_data = 24'h0;
    logic [23:0] data_out;
    logic [2:0]  pos;
    logic        step;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [23:0] data;
        logic [2:0]  pos;
        logic        wrap;
        int          at;
    } exp_t;
    exp_t sb[$];

    seg_scroll_ctrl #(
        .DIGITS(6), .DW(4), .CLK_HZ(8), .STEP_HZ(1),
        .INIT(24'h012345), .PAUSE_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .speed(speed),
        .load(load), .load_data(load_data),
        .data_out(data_out), .pos(pos), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic [2:0] p, input logic w, input int at);
        exp_t e;
        e.data = d; e.pos = p; e.wrap = w; e.at = at;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [23:0] d);
        load = 1'b1;
        load_data = d;
        @(negedge clk);
        load = 1'b0;
        check("load_data", 32'(data_out), 32'(d));
        check("load_pos", 32'(pos), 32'd0);
        check("load_step", 32'(step), 32'd0);
    endtask

    // Monitor: every step pulse must match the oldest expected shift.
    initial begin
        forever begin
            @(negedge clk);
            if (step) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: got step at cycle %0d data %h, expected none", cyc, data_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("step_cycle", 32'(cyc), 32'(e.at));
                    check("step_data", 32'(data_out), 32'(e.data));
                    check("step_pos", 32'(pos), 32'(e.pos));
                    check("step_wrap", 32'(wrap), 32'(e.wrap));
                end
            end else if (wrap) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_without_step: got wrap=1 step=0 at cycle %0d, expected wrap=0", cyc);
            end
        end
    end

    initial begin
        int c;
        repeat (2) @(negedge clk);
        check("reset_data", 32'(data_out), 32'h012345);
        check("reset_pos", 32'(pos), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        rst = 1'b0;

        // Full right revolution at speed 0
        en = 1'b1;
        c = cyc;
        push(24'h501234, 3'd1, 1'b0, c + 8);
        push(24'h450123, 3'd2, 1'b0, c + 16);
        push(24'h345012, 3'd3, 1'b0, c + 24);
        push(24'h234501, 3'd4, 1'b0, c + 32);
        push(24'h123450, 3'd5, 1'b0, c + 40);
        push(24'h012345, 3'd0, 1'b1, c + 48);
        repeat (48) @(negedge clk);
        en = 1'b0;
        do_load(24'h012345);

        // Left step, then direction flip before the next tick
        dir = 1'b1;
        en = 1'b1;
        c = cyc;
        push(24'h123450, 3'd5, 1'b0, c + 8);
        repeat (8) @(negedge clk);
        dir = 1'b0;
        push(24'h012345, 3'd0, 1'b1, c + 16);
        repeat (8) @(negedge clk);
        en = 1'b0;
        do_load(24'h012345);

        // Speed 2, then 0 to cnt=5, then 3 (clear without tick, then every cycle)
        speed = 2'd2;
        en = 1'b1;
        c = cyc;
        push(24'h501234, 3'd1, 1'b0, c + 2);
        push(24'h450123, 3'd2, 1'b0, c + 4);
        repeat (4) @(negedge clk);
        speed = 2'd0;
        repeat (5) @(negedge clk);
        speed = 2'd3;
        push(24'h345012, 3'd3, 1'b0, c + 11);
        push(24'h234501, 3'd4, 1'b0, c + 12);
        repeat (3) @(negedge clk);
        en = 1'b0;
        speed = 2'd0;

        // Load mid-count, then load coinciding with a tick
        en = 1'b1;
        repeat (3) @(negedge clk);
        do_load(24'hABCDEF);
        c = cyc;
        push(24'hFABCDE, 3'd1, 1'b0, c + 8);
        repeat (15) @(negedge clk);
        do_load(24'h012345);
        en = 1'b0;

        // en falls exactly at cnt==LIM, then a long hold
        en = 1'b1;
        c = cyc;
        push(24'h501234, 3'd1, 1'b0, c + 8);
        repeat (15) @(negedge clk);
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("hold_data", 32'(data_out), 32'h501234);
            check("hold_pos", 32'(pos), 32'd1);
            check("hold_step", 32'(step), 32'd0);
        end

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", 32'(data_out), 32'h012345);
        check("async_rst_pos", 32'(pos), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef SCROLL_DWELL_EN
        // Two silent dwell ticks after the wrap, shift on the third
        en = 1'b1;
        c = cyc;
        push(24'h501234, 3'd1, 1'b0, c + 8);
        push(24'h450123, 3'd2, 1'b0, c + 16);
        push(24'h345012, 3'd3, 1'b0, c + 24);
        push(24'h234501, 3'd4, 1'b0, c + 32);
        push(24'h123450, 3'd5, 1'b0, c + 40);
        push(24'h012345, 3'd0, 1'b1, c + 48);
        push(24'h501234, 3'd1, 1'b0, c + 72);
        repeat (64) @(negedge clk);
        check("dwell_data", 32'(data_out), 32'h012345);
        repeat (8) @(negedge clk);
        en = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
